// File: rtl/histogram_readout_ctrl.sv
// histogram_readout_ctrl: at every frame end, sweeps the histogram RAM and streams each bin
// over valid/ready while gathering total/peak statistics, then pulses the histogram clear.
module histogram_readout_ctrl #(
   parameter int ADDR_W     = 10,
   parameter int CNT_W      = 16,
   parameter int SUM_W      = 32,
   parameter bit AUTO_CLEAR = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic              frame_valid,
   output logic              hist_rd_en,
   output logic [ADDR_W-1:0] hist_rd_addr,
   input  logic [CNT_W-1:0]  hist_rd_data,
   output logic              hist_clear,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] out_addr,
   output logic [CNT_W-1:0]  out_data,
   output logic              out_last,
   output logic              busy,
   output logic              stats_valid,
   output logic [SUM_W-1:0]  total_count,
   output logic [ADDR_W-1:0] peak_bin,
   output logic [CNT_W-1:0]  peak_count,
   output logic              sweep_abort
);
   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   typedef enum logic [2:0] {IDLE, READ, WAIT_DATA, SEND, CLEAR} state_t;

   state_t            state_reg, state_next;
   logic              fv_d_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [SUM_W-1:0]  sum_reg;
   logic [ADDR_W-1:0] peak_bin_acc_reg;
   logic [CNT_W-1:0]  peak_cnt_acc_reg;
   logic [CNT_W-1:0]  out_data_reg;
   logic [ADDR_W-1:0] out_addr_reg;
   logic              out_last_reg;
   logic [SUM_W-1:0]  total_reg;
   logic [ADDR_W-1:0] peak_bin_reg;
   logic [CNT_W-1:0]  peak_count_reg;
   logic              abort_reg;

   logic              fv_fall, in_sweep, abort, handshake, new_peak;
   logic [SUM_W-1:0]  sum_plus;
   logic [ADDR_W-1:0] peak_bin_upd;
   logic [CNT_W-1:0]  peak_cnt_upd;

   assign fv_fall   = fv_d_reg & ~frame_valid;
   assign in_sweep  = (state_reg == READ) || (state_reg == WAIT_DATA) || (state_reg == SEND);
   assign abort     = in_sweep & frame_valid;
   // A beat is never accepted in the cycle the sweep is being aborted.
   assign handshake = (state_reg == SEND) & ~frame_valid & out_ready;

   assign new_peak     = out_data_reg > peak_cnt_acc_reg;
   assign sum_plus     = sum_reg + SUM_W'(out_data_reg);
   assign peak_bin_upd = new_peak ? out_addr_reg : peak_bin_acc_reg;
   assign peak_cnt_upd = new_peak ? out_data_reg : peak_cnt_acc_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      hist_rd_en   = 1'b0;
      hist_rd_addr = addr_reg;
      hist_clear   = 1'b0;
      out_valid    = 1'b0;
      stats_valid  = 1'b0;
      busy         = (state_reg != IDLE);
      case (state_reg)
         IDLE: begin
            if (fv_fall && enable) state_next = READ;
         end
         READ: begin
            hist_rd_en = ~frame_valid;
            state_next = WAIT_DATA;
         end
         WAIT_DATA: begin
            state_next = SEND;
         end
         SEND: begin
            out_valid = ~frame_valid;
            if (handshake) state_next = out_last_reg ? CLEAR : READ;
         end
         CLEAR: begin
            hist_clear  = AUTO_CLEAR;
            stats_valid = 1'b1;
            state_next  = IDLE;
         end
         default: state_next = IDLE;
      endcase
      if (abort) state_next = IDLE;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fv_d_reg         <= 1'b0;
         addr_reg         <= '0;
         sum_reg          <= '0;
         peak_bin_acc_reg <= '0;
         peak_cnt_acc_reg <= '0;
         out_data_reg     <= '0;
         out_addr_reg     <= '0;
         out_last_reg     <= 1'b0;
         total_reg        <= '0;
         peak_bin_reg     <= '0;
         peak_count_reg   <= '0;
         abort_reg        <= 1'b0;
      end else begin
         fv_d_reg  <= frame_valid;
         abort_reg <= abort;
         case (state_reg)
            IDLE: begin
               if (fv_fall && enable) begin
                  addr_reg         <= '0;
                  sum_reg          <= '0;
                  peak_bin_acc_reg <= '0;
                  peak_cnt_acc_reg <= '0;
               end
            end
            WAIT_DATA: begin
               out_data_reg <= hist_rd_data;
               out_addr_reg <= addr_reg;
               out_last_reg <= (addr_reg == LAST_ADDR);
            end
            SEND: begin
               if (handshake) begin
                  sum_reg          <= sum_plus;
                  peak_bin_acc_reg <= peak_bin_upd;
                  peak_cnt_acc_reg <= peak_cnt_upd;
                  // Stats land with the final beat so they are already valid while stats_valid is high.
                  if (out_last_reg) begin
                     total_reg      <= sum_plus;
                     peak_bin_reg   <= peak_bin_upd;
                     peak_count_reg <= peak_cnt_upd;
                  end else begin
                     addr_reg <= addr_reg + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign out_addr    = out_addr_reg;
   assign out_data    = out_data_reg;
   assign out_last    = out_last_reg;
   assign total_count = total_reg;
   assign peak_bin    = peak_bin_reg;
   assign peak_count  = peak_count_reg;
   assign sweep_abort = abort_reg;
endmodule

// File: tb/tb_histogram_readout_ctrl.sv
// Bench for histogram_readout_ctrl: table of full sweeps plus abort, enable and reset sequences,
// all beats checked against a snapshot of the histogram contents.
`timescale 1ns/1ps
module tb_histogram_readout_ctrl;
   localparam int NB = 1024;

   logic        clk = 1'b0, reset = 1'b1, enable = 1'b1, frame_valid = 1'b0, out_ready = 1'b0;
   logic        hist_rd_en, hist_clear, out_valid, out_last, busy, stats_valid, sweep_abort;
   logic [9:0]  hist_rd_addr, out_addr, peak_bin;
   logic [15:0] hist_rd_data, out_data, peak_count;
   logic [31:0] total_count;
   logic        nc_rd_en, nc_clear, nc_valid, nc_last, nc_busy, nc_stats_valid, nc_abort;
   logic [9:0]  nc_rd_addr, nc_out_addr, nc_peak_bin;
   logic [15:0] nc_out_data, nc_peak_count;
   logic [31:0] nc_total;

   always #5 clk = ~clk;

   histogram_readout_ctrl dut (
      .clk(clk), .reset(reset), .enable(enable), .frame_valid(frame_valid),
      .hist_rd_en(hist_rd_en), .hist_rd_addr(hist_rd_addr), .hist_rd_data(hist_rd_data),
      .hist_clear(hist_clear), .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
      .out_data(out_data), .out_last(out_last), .busy(busy), .stats_valid(stats_valid),
      .total_count(total_count), .peak_bin(peak_bin), .peak_count(peak_count),
      .sweep_abort(sweep_abort));

   histogram_readout_ctrl #(.AUTO_CLEAR(1'b0)) dut_nc (
      .clk(clk), .reset(reset), .enable(enable), .frame_valid(frame_valid),
      .hist_rd_en(nc_rd_en), .hist_rd_addr(nc_rd_addr), .hist_rd_data(hist_rd_data),
      .hist_clear(nc_clear), .out_valid(nc_valid), .out_ready(out_ready), .out_addr(nc_out_addr),
      .out_data(nc_out_data), .out_last(nc_last), .busy(nc_busy), .stats_valid(nc_stats_valid),
      .total_count(nc_total), .peak_bin(nc_peak_bin), .peak_count(nc_peak_count),
      .sweep_abort(nc_abort));

   logic [15:0] mem [NB];
   logic [15:0] exp_mem [NB];

   always @(posedge clk) begin
      if (hist_rd_en) hist_rd_data <= mem[hist_rd_addr];
   end

   int checks = 0, errors = 0;
   int exp_idx = 0, clears = 0, stats_cnt = 0, aborts = 0, rd_cycles = 0, busy_cycles = 0;
   int nc_clears = 0, nc_stats = 0;
   int ready_pct = 100;
   logic [31:0] cap_total;
   logic [9:0]  cap_pb;
   logic [15:0] cap_pc;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // Randomised ready, updated just after each rising edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         out_ready = (int'($urandom_range(99)) < ready_pct);
      end
   end

   // Stream monitor: beat order/content, hold-while-stalled, and event counters
   initial begin
      logic        prev_stall;
      logic [9:0]  prev_addr;
      logic [15:0] prev_data;
      prev_stall = 1'b0;
      prev_addr  = '0;
      prev_data  = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               if (out_valid) begin
                  chk("hold_addr", 32'(out_addr), 32'(prev_addr));
                  chk("hold_data", 32'(out_data), 32'(prev_data));
               end else begin
                  chk("valid_drop_without_abort", 32'(frame_valid), 32'd1);
               end
            end
            if (out_valid && out_ready) begin
               if (exp_idx >= NB) begin
                  chk("extra_beat", 32'(exp_idx), 32'(NB - 1));
               end else begin
                  chk("beat_addr", 32'(out_addr), 32'(exp_idx));
                  chk("beat_data", 32'(out_data), 32'(exp_mem[exp_idx]));
                  chk("beat_last", 32'(out_last), 32'(exp_idx == NB - 1));
               end
               exp_idx++;
            end
            if (hist_rd_en) begin
               rd_cycles++;
               chk("rd_en_while_fv", 32'(frame_valid), 32'd0);
            end
            if (busy) busy_cycles++;
            if (hist_clear) clears++;
            if (sweep_abort) aborts++;
            if (nc_clear) nc_clears++;
            if (nc_stats_valid) nc_stats++;
            if (stats_valid) begin
               stats_cnt++;
               cap_total = total_count;
               cap_pb    = peak_bin;
               cap_pc    = peak_count;
            end
            prev_stall = out_valid && !out_ready;
            prev_addr  = out_addr;
            prev_data  = out_data;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic fill(input int kind);
      for (int i = 0; i < NB; i++) begin
         case (kind)
            0:       mem[i] = (i == 5 || i == 900) ? 16'd100 : 16'd0;
            1:       mem[i] = 16'd1;
            2:       mem[i] = 16'(i);
            3:       mem[i] = (i == 7 || i == 1023) ? 16'hFFFF : 16'(i & 3);
            default: mem[i] = ($urandom_range(3) == 0) ? 16'($urandom_range(40)) : 16'd0;
         endcase
         exp_mem[i] = mem[i];
      end
   endtask

   // Reference: sum of all bins, first index of the maximum
   task automatic model(output logic [31:0] t, output logic [9:0] pb, output logic [15:0] pc);
      t = 0; pb = 0; pc = 0;
      for (int i = 0; i < NB; i++) begin
         t += 32'(exp_mem[i]);
         if (exp_mem[i] > pc) begin
            pc = exp_mem[i];
            pb = 10'(i);
         end
      end
   endtask

   task automatic reset_counts;
      exp_idx = 0; clears = 0; stats_cnt = 0; aborts = 0; rd_cycles = 0; busy_cycles = 0;
      nc_clears = 0; nc_stats = 0;
   endtask

   task automatic frame_end;
      frame_valid = 1'b1;
      tick(3);
      frame_valid = 1'b0;
   endtask

   task automatic wait_stats(input int limit);
      int n;
      n = 0;
      while (n < limit && stats_cnt == 0) begin
         tick(1);
         n++;
      end
      chk("sweep_completes", 32'(stats_cnt != 0), 32'd1);
      tick(2);
   endtask

   typedef struct {
      int          kind;
      int          ready_pct;
      logic [31:0] total;
      logic [9:0]  pb;
      logic [15:0] pc;
   } vec_t;

   vec_t vecs[8];

   initial begin
      vecs[0] = '{0, 100, 32'd200,    10'd5,    16'd100};
      vecs[1] = '{0, 50,  32'd200,    10'd5,    16'd100};
      vecs[2] = '{1, 100, 32'd1024,   10'd0,    16'd1};
      vecs[3] = '{2, 75,  32'd523776, 10'd1023, 16'd1023};
      vecs[4] = '{3, 60,  32'd132600, 10'd7,    16'hFFFF};
      for (int v = 5; v < 8; v++) vecs[v] = '{9, int'($urandom_range(30, 100)), 32'd0, 10'd0, 16'd0};

      tick(3);
      chk("reset_outputs_zero", 32'(|{hist_rd_en, hist_rd_addr, hist_clear, out_valid, out_addr,
          out_data, out_last, busy, stats_valid, total_count, peak_bin, peak_count, sweep_abort}), 32'd0);
      reset = 1'b0;
      tick(2);

      for (int v = 0; v < 8; v++) begin
         fill(vecs[v].kind);
         if (vecs[v].kind == 9) model(vecs[v].total, vecs[v].pb, vecs[v].pc);
         ready_pct = vecs[v].ready_pct;
         reset_counts();
         frame_end();
         wait_stats(20000);
         chk("beats", 32'(exp_idx), 32'(NB));
         chk("rd_cycles", 32'(rd_cycles), 32'(NB));
         chk("total_count", cap_total, vecs[v].total);
         chk("peak_bin", 32'(cap_pb), 32'(vecs[v].pb));
         chk("peak_count", 32'(cap_pc), 32'(vecs[v].pc));
         chk("clear_pulses", 32'(clears), 32'd1);
         chk("stats_pulses", 32'(stats_cnt), 32'd1);
         chk("stats_hold", total_count, vecs[v].total);
         chk("noclear_clear_pulses", 32'(nc_clears), 32'd0);
         chk("noclear_stats_pulses", 32'(nc_stats), 32'd1);
         if (ready_pct == 100) chk("sweep_cycles", 32'(busy_cycles + 1), 32'(3 * NB + 2));
         $display("sweep %0d kind=%0d ready=%0d%% total=%0d peak_bin=%0d peak_count=%0d",
                  v, vecs[v].kind, ready_pct, cap_total, cap_pb, cap_pc);
      end

      // Abort while reading bin 300: stats keep the previous sweep's values
      begin
         int n;
         fill(0);
         ready_pct = 100;
         reset_counts();
         frame_end();
         n = 0;
         while (n < 5000 && !(hist_rd_en && hist_rd_addr == 10'd300)) begin
            tick(1);
            n++;
         end
         chk("reached_bin_300", 32'(hist_rd_addr), 32'd300);
         frame_valid = 1'b1;
         tick(1);
         chk("abort_pulse", 32'(sweep_abort), 32'd1);
         chk("abort_valid_low", 32'(out_valid), 32'd0);
         chk("abort_busy_low", 32'(busy), 32'd0);
         tick(1);
         chk("abort_single_pulse", 32'(sweep_abort), 32'd0);
         chk("abort_count", 32'(aborts), 32'd1);
         chk("abort_beats", 32'(exp_idx), 32'd300);
         chk("abort_no_clear", 32'(clears), 32'd0);
         chk("abort_no_stats", 32'(stats_cnt), 32'd0);
         chk("abort_stats_kept", total_count, vecs[7].total);
         chk("abort_peak_kept", 32'(peak_count), 32'(vecs[7].pc));
         reset_counts();
         frame_valid = 1'b0;
         wait_stats(20000);
         chk("restart_beats", 32'(exp_idx), 32'(NB));
         chk("restart_total", cap_total, 32'd200);
         chk("restart_peak_bin", 32'(cap_pb), 32'd5);
         $display("abort at bin 300 then restart: total=%0d", cap_total);
      end

      // enable low at frame end: nothing happens; enable dropped mid-sweep: sweep completes
      enable = 1'b0;
      reset_counts();
      frame_end();
      tick(20);
      chk("disabled_rd_cycles", 32'(rd_cycles), 32'd0);
      chk("disabled_busy", 32'(busy_cycles), 32'd0);
      enable = 1'b1;
      fill(1);
      reset_counts();
      frame_end();
      tick(50);
      enable = 1'b0;
      wait_stats(20000);
      chk("enable_drop_beats", 32'(exp_idx), 32'(NB));
      chk("enable_drop_total", cap_total, 32'd1024);
      enable = 1'b1;
      $display("enable gating: idle when disabled, mid-sweep drop total=%0d", cap_total);

      // Reset while stalled in SEND: outputs clear without waiting for a clock edge
      begin
         int n;
         fill(2);
         ready_pct = 0;
         reset_counts();
         frame_end();
         n = 0;
         while (n < 100 && !out_valid) begin
            tick(1);
            n++;
         end
         chk("send_reached", 32'(out_valid), 32'd1);
         reset = 1'b1;
         #1;
         chk("async_reset_zero", 32'(|{hist_rd_en, hist_rd_addr, hist_clear, out_valid, out_addr,
             out_data, out_last, busy, stats_valid, total_count, peak_bin, peak_count, sweep_abort}), 32'd0);
         tick(3);
         reset = 1'b0;
         ready_pct = 100;
         reset_counts();
         tick(30);
         chk("post_reset_no_sweep", 32'(busy_cycles + rd_cycles), 32'd0);
         $display("reset mid-send: outputs cleared, no sweep after release");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
